// File: rtl/ring_osc_trim_cal_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ring_osc_trim_cal_pkg
// Description : Shared types, constants and the code-to-trim mapping for the
//               ring oscillator trim calibrator.
//               Contents: cal_state_e state enum, stage/code constants,
//               code2trim() thermometer mapping.
// Revision    : 1.0 - initial release
//==============================================================================
package ring_osc_trim_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_EVAL   = 3'd4,
        ST_FIN    = 3'd5
    } cal_state_e;

    localparam int NUM_STAGES = 13;
    localparam int CODE_MAX   = 26;
    localparam int RST_CYCLES = 4;
    localparam int TRIM_W     = 2 * NUM_STAGES;

    // Thermometer mapping: the primary bank fills completely before any
    // secondary bit is set, so each code step adds exactly one loading stage.
    function automatic logic [TRIM_W-1:0] code2trim(input logic [4:0] code);
        logic [TRIM_W-1:0] t;
        int                k;
        k = int'(code);
        if (k > CODE_MAX) begin
            k = CODE_MAX;
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            t[i]              = (i < k);
            t[NUM_STAGES + i] = (i < (k - NUM_STAGES));
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_osc_trim_cal_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : osc_edge_counter
// Description : Brings the pre-divided oscillator tap into the core clock
//               domain and counts its rising edges.
//               Ports: core_clk/resetb (clock, async active-low reset),
//               osc_div_i (asynchronous tap), clr_i (synchronous clear,
//               dominant), en_i (count enable), count_o (saturating count).
// Revision    : 1.0 - initial release
//==============================================================================
module osc_edge_counter #(
    parameter int CNT_W = 12
) (
    input  logic             core_clk,
    input  logic             resetb,
    input  logic             osc_div_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_rise;

    // sync1/sync2 resolve metastability; sync3 holds the previous sample
    // so a rising edge is a single-cycle event in the core domain.
    assign w_rise = sync2_q & ~sync3_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && w_rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= osc_div_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ring_osc_trim_cal.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ring_osc_trim_cal
// Description : Closed-loop trim calibrator for the 13-stage ring oscillator.
//               Resets the oscillator, measures divided-tap edges over a fixed
//               window and binary-searches the 27-step trim code toward a
//               target count.
//               Ports: core_clk, resetb (async active-low), start, target,
//               osc_div (async tap) in; osc_reset, trim[25:0], busy, done,
//               locked, fail, code[4:0], count out.
// Revision    : 1.0 - initial release
//==============================================================================
module ring_osc_trim_cal #(
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 12,
    parameter int TOL    = 2,
    parameter int SETTLE = 16
) (
    input  logic             core_clk,
    input  logic             resetb,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             osc_div,
    output logic             osc_reset,
    output logic [25:0]      trim,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [4:0]       code,
    output logic [CNT_W-1:0] count
);
    import ring_osc_trim_cal_pkg::*;

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0]    RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]    SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]    WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W:0]      TOL_V       = (CNT_W + 1)'(TOL);
    localparam logic signed [5:0]   HI_INIT     = 6'(CODE_MAX);
    localparam logic [4:0]          CODE_MID    = 5'(CODE_MAX / 2);
    localparam logic [4:0]          CODE_SAFE   = 5'(CODE_MAX);

    cal_state_e         state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   target_q, target_d;
    // lo/hi carry a sign bit so that hi = code-1 at code 0 reads as -1.
    logic signed [5:0]  lo_q, lo_d;
    logic signed [5:0]  hi_q, hi_d;
    logic [4:0]         code_q, code_d;
    logic [TRIM_W-1:0]  trim_q, trim_d;
    logic               osc_reset_q, osc_reset_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [4:0]         best_code_q, best_code_d;
    logic [CNT_W:0]     best_err_q, best_err_d;

    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_meas_cnt;
    logic signed [CNT_W:0] w_err;
    logic [CNT_W:0]     w_abs_err;
    logic               w_too_fast;
    logic               w_better;
    logic [4:0]         w_best_code;
    logic [CNT_W:0]     w_best_err;
    logic signed [5:0]  w_lo_upd;
    logic signed [5:0]  w_hi_upd;
    logic [6:0]         w_sum;
    logic [4:0]         w_mid;

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .core_clk  (core_clk),
        .resetb    (resetb),
        .osc_div_i (osc_div),
        .clr_i     (w_cnt_clr),
        .en_i      (w_cnt_en),
        .count_o   (w_meas_cnt)
    );

    //--------------------------------------------------------------------------
    // Evaluation datapath (only consumed in ST_EVAL)
    //--------------------------------------------------------------------------
    assign w_err      = $signed({1'b0, w_meas_cnt}) - $signed({1'b0, target_q});
    assign w_abs_err  = w_err[CNT_W] ? $unsigned(-w_err) : $unsigned(w_err);
    assign w_too_fast = (w_meas_cnt > target_q);

    assign w_better    = (w_abs_err < best_err_q);
    assign w_best_code = w_better ? code_q    : best_code_q;
    assign w_best_err  = w_better ? w_abs_err : best_err_q;

    // Too fast means too little loading: move the lower bound above code.
    always_comb begin
        w_lo_upd = lo_q;
        w_hi_upd = hi_q;
        if (w_too_fast) begin
            w_lo_upd = $signed({1'b0, code_q}) + 6'sd1;
        end else begin
            w_hi_upd = $signed({1'b0, code_q}) - 6'sd1;
        end
    end

    // Only used when lo <= hi, where both bounds are non-negative.
    assign w_sum = {1'b0, w_lo_upd} + {1'b0, w_hi_upd};
    assign w_mid = w_sum[5:1];

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        target_d    = target_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        code_d      = code_q;
        locked_d    = locked_q;
        fail_d      = fail_q;
        count_d     = count_q;
        best_code_d = best_code_q;
        best_err_d  = best_err_q;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RST;
                    tmr_d       = '0;
                    target_d    = target;
                    lo_d        = 6'sd0;
                    hi_d        = HI_INIT;
                    code_d      = CODE_MID;
                    locked_d    = 1'b0;
                    fail_d      = 1'b0;
                    best_code_d = '0;
                    // Larger than any possible |count-target|, so the first
                    // evaluation always records a best code.
                    best_err_d  = '1;
                end
            end

            ST_RST: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_SETTLE: begin
                w_cnt_clr = 1'b1;
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_MEAS;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_MEAS: begin
                w_cnt_en = 1'b1;
                if (tmr_q == WINDOW_LAST) begin
                    state_d = ST_EVAL;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_EVAL: begin
                count_d     = w_meas_cnt;
                best_code_d = w_best_code;
                best_err_d  = w_best_err;
                if (w_abs_err <= TOL_V) begin
                    locked_d = 1'b1;
                    state_d  = ST_FIN;
                end else begin
                    lo_d = w_lo_upd;
                    hi_d = w_hi_upd;
                    if (w_lo_upd > w_hi_upd) begin
                        code_d  = w_best_code;
                        fail_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        code_d  = w_mid;
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        osc_reset_d = (state_d == ST_RST);
        trim_d      = code2trim(code_d);
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge core_clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            target_q    <= '0;
            lo_q        <= 6'sd0;
            hi_q        <= HI_INIT;
            code_q      <= CODE_SAFE;
            trim_q      <= {TRIM_W{1'b1}};
            osc_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            count_q     <= '0;
            best_code_q <= '0;
            best_err_q  <= '1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            target_q    <= target_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            code_q      <= code_d;
            trim_q      <= trim_d;
            osc_reset_q <= osc_reset_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            count_q     <= count_d;
            best_code_q <= best_code_d;
            best_err_q  <= best_err_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign osc_reset = osc_reset_q;
    assign trim      = trim_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done      = (state_q == ST_FIN);
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign code      = code_q;
    assign count     = count_q;

endmodule
`default_nettype wire
